// File: rtl/fast_accel_hls_deadlock_report_unit.sv
// Collects per-process deadlock detects, picks an origin, traces the token ring and reports the cycle.
// Latency: origin driven 1 cycle after detect; report valid 2 cycles after the token returns (or timeout).
// Backpressure: report held stable in REPORT until rpt_ready; unit then parks in DONE until reset.
module fast_accel_hls_deadlock_report_unit #(
  parameter int PROC_NUM       = 4,
  parameter int PROC_ID_W      = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PROC_NUM-1:0]  dl_detect_in_vec,
  input  logic [PROC_NUM-1:0]  token_vld_vec,
  output logic                 dl_detect_global,
  output logic [PROC_NUM-1:0]  origin_vec,
  output logic                 token_clear,
  output logic                 rpt_valid,
  input  logic                 rpt_ready,
  output logic [PROC_ID_W-1:0] rpt_origin_id,
  output logic [PROC_NUM-1:0]  rpt_proc_mask,
  output logic [PROC_ID_W:0]   rpt_len,
  output logic                 rpt_timeout
);

  localparam int          LEN_W    = PROC_ID_W + 1;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ORIGIN,
    S_TRACE,
    S_CLEAR,
    S_REPORT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [PROC_ID_W-1:0]   origin_id_q, origin_id_d;
  logic [PROC_NUM-1:0]    mask_q, mask_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [PROC_ID_W-1:0]   rpt_origin_id_q, rpt_origin_id_d;
  logic [PROC_NUM-1:0]    rpt_proc_mask_q, rpt_proc_mask_d;
  logic [LEN_W-1:0]       rpt_len_q, rpt_len_d;
  logic                   rpt_timeout_q, rpt_timeout_d;

  logic [PROC_ID_W-1:0]   low_idx;
  logic [LEN_W-1:0]       mask_pop;
  logic [PROC_NUM-1:0]    origin_onehot;

  // Fixed-priority pick: lowest-index detecting process becomes the origin.
  always_comb begin
    low_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (dl_detect_in_vec[i]) low_idx = PROC_ID_W'(i);
    end
  end

  // Number of processes the token has visited so far.
  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < PROC_NUM; i++) begin
      mask_pop = mask_pop + LEN_W'(mask_q[i]);
    end
  end

  assign origin_onehot = PROC_NUM'(1) << origin_id_q;

  // Outputs decode from registered state only.
  assign dl_detect_global = (state_q != S_IDLE);
  assign origin_vec       = (state_q == S_ORIGIN) ? origin_onehot : '0;
  assign token_clear      = (state_q == S_CLEAR);
  assign rpt_valid        = (state_q == S_REPORT);
  assign rpt_origin_id    = rpt_origin_id_q;
  assign rpt_proc_mask    = rpt_proc_mask_q;
  assign rpt_len          = rpt_len_q;
  assign rpt_timeout      = rpt_timeout_q;

  // Next-state logic: detect -> origin pulse -> trace ring -> clear tokens -> report -> park.
  always_comb begin
    state_d         = state_q;
    origin_id_d     = origin_id_q;
    mask_d          = mask_q;
    cnt_d           = cnt_q;
    rpt_origin_id_d = rpt_origin_id_q;
    rpt_proc_mask_d = rpt_proc_mask_q;
    rpt_len_d       = rpt_len_q;
    rpt_timeout_d   = rpt_timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (|dl_detect_in_vec) begin
          origin_id_d = low_idx;
          mask_d      = PROC_NUM'(1) << low_idx;
          cnt_d       = '0;
          state_d     = S_ORIGIN;
        end
      end
      S_ORIGIN: state_d = S_TRACE;
      S_TRACE: begin
        mask_d = mask_q | token_vld_vec;
        cnt_d  = cnt_q + 16'd1;
        // Token return wins over a timeout landing on the same cycle.
        if (token_vld_vec[origin_id_q]) begin
          rpt_timeout_d = 1'b0;
          state_d       = S_CLEAR;
        end else if (cnt_q == CNT_LAST) begin
          rpt_timeout_d = 1'b1;
          state_d       = S_CLEAR;
        end
      end
      S_CLEAR: begin
        rpt_origin_id_d = origin_id_q;
        rpt_proc_mask_d = mask_q;
        rpt_len_d       = mask_pop;
        state_d         = S_REPORT;
      end
      S_REPORT: begin
        if (rpt_ready) state_d = S_DONE;
      end
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      origin_id_q     <= '0;
      mask_q          <= '0;
      cnt_q           <= '0;
      rpt_origin_id_q <= '0;
      rpt_proc_mask_q <= '0;
      rpt_len_q       <= '0;
      rpt_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      origin_id_q     <= origin_id_d;
      mask_q          <= mask_d;
      cnt_q           <= cnt_d;
      rpt_origin_id_q <= rpt_origin_id_d;
      rpt_proc_mask_q <= rpt_proc_mask_d;
      rpt_len_q       <= rpt_len_d;
      rpt_timeout_q   <= rpt_timeout_d;
    end
  end

endmodule
